// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin arbiter sharing one signed WIDTHxWIDTH multiplier among NREQ requesters
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   req[NREQ]      : per-requester request, held with stable operands until granted
//   a_in, x_in     : packed signed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt[NREQ]      : one-cycle one-hot grant (MUL cycle)
//   rsp_valid[NREQ]: one-cycle one-hot response strobe (RESP cycle)
//   result         : full-precision signed product of the last completed operation
//   busy           : high whenever the sequencer is not idle
module mult_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] x_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    result,
    output logic                  busy
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
    state_t                    state_q, state_d;
    logic [IW-1:0]             ptr_q, ptr_d, id_q, id_d, win;
    logic signed [WIDTH-1:0]   op_a_q, op_a_d, op_x_q, op_x_d, win_a, win_x;
    logic [NREQ-1:0]           gnt_q, gnt_d, rsp_q, rsp_d;
    logic signed [2*WIDTH-1:0] result_q, result_d, prod;
    logic [IW-1:0]             cand [NREQ];
    logic [WIDTH-1:0]          a_arr [NREQ];
    logic [WIDTH-1:0]          x_arr [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        // cand[i] is the i-th requester in priority order, starting at ptr
        assign cand[i]  = IW'((int'(ptr_q) + i) % NREQ);
        assign a_arr[i] = a_in[i*WIDTH +: WIDTH];
        assign x_arr[i] = x_in[i*WIDTH +: WIDTH];
    end
    // The single shared multiplier; signed operands are sign-extended to the full product width.
    assign prod = op_a_q * op_x_q;
    // Descending scan so the lowest-offset requesting candidate overwrites the rest.
    always_comb begin
        win   = '0;
        win_a = '0;
        win_x = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                win   = cand[k];
                win_a = a_arr[cand[k]];
                win_x = x_arr[cand[k]];
            end
        end
    end
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        op_a_d   = op_a_q;
        op_x_d   = op_x_q;
        gnt_d    = '0;
        rsp_d    = '0;
        result_d = result_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = MUL;
                id_d    = win;
                op_a_d  = win_a;
                op_x_d  = win_x;
                gnt_d   = NREQ'(1) << win;
            end
            MUL: begin
                state_d  = RESP;
                result_d = prod;
                rsp_d    = NREQ'(1) << id_q;
            end
            default: begin
                state_d = IDLE;
                ptr_d   = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            op_a_q   <= '0;
            op_x_q   <= '0;
            gnt_q    <= '0;
            rsp_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            op_a_q   <= op_a_d;
            op_x_q   <= op_x_d;
            gnt_q    <= gnt_d;
            rsp_q    <= rsp_d;
            result_q <= result_d;
        end
    end
    assign gnt       = gnt_q;
    assign rsp_valid = rsp_q;
    assign result    = result_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: self-checking bench for mult_share_arb (vector table, directed sequences, random vs model)
module tb_mult_share_arb;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] a_in = '0;
    logic [NREQ*WIDTH-1:0] x_in = '0;
    logic [NREQ-1:0]       gnt, rsp_valid;
    logic [2*WIDTH-1:0]    result;
    logic                  busy;
    int errors = 0;
    int checks = 0;

    mult_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .x_in(x_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int a; int x; int p; } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int x);
        a_in[i*WIDTH +: WIDTH] = WIDTH'(a);
        x_in[i*WIDTH +: WIDTH] = WIDTH'(x);
    endtask

    task automatic do_reset();
        req = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic int sres();
        return int'($signed(result));
    endfunction

    // One isolated transaction starting from an idle cycle.
    task automatic do_op(input int i, input int a, input int x, input int p);
        set_ops(i, a, x);
        req[i] = 1'b1;
        tick();
        chk("op_gnt", int'(gnt), 1 << i);
        chk("op_busy_mul", int'(busy), 1);
        chk("op_rsp_mul", int'(rsp_valid), 0);
        req[i] = 1'b0;
        tick();
        chk("op_rsp", int'(rsp_valid), 1 << i);
        chk("op_gnt_resp", int'(gnt), 0);
        chk("op_result", sres(), p);
        chk("op_busy_resp", int'(busy), 1);
        tick();
        chk("op_busy_idle", int'(busy), 0);
        chk("op_rsp_idle", int'(rsp_valid), 0);
        chk("op_result_hold", sres(), p);
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    int sim_p[4] = '{2, -12, -30, 56};
    int order[$];
    int ma[NREQ];
    int mx[NREQ];
    logic [NREQ-1:0] r, eg, er;
    int last, phase, cur, eres, w;
    byte sa, sx;

    initial begin
        vecs[0] = '{0, 7, 11, 77};
        vecs[1] = '{1, -128, -128, 16384};
        vecs[2] = '{2, -128, 127, -16256};
        vecs[3] = '{3, 0, -1, 0};
        vecs[4] = '{0, -1, -1, 1};
        vecs[5] = '{3, 127, 127, 16129};

        tick();
        tick();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_rsp", int'(rsp_valid), 0);
        chk("rst_result", sres(), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        foreach (vecs[n]) do_op(vecs[n].idx, vecs[n].a, vecs[n].x, vecs[n].p);

        // All four requesters at once from reset: served 0..3, three cycles apart.
        do_reset();
        set_ops(0, 1, 2);
        set_ops(1, -3, 4);
        set_ops(2, 5, -6);
        set_ops(3, -7, -8);
        req = '1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("sim_gnt", int'(gnt), (c % 3 == 1) ? 1 << ((c - 1) / 3) : 0);
            chk("sim_rsp", int'(rsp_valid), (c % 3 == 2) ? 1 << ((c - 2) / 3) : 0);
            if (c % 3 == 2) chk("sim_result", sres(), sim_p[(c - 2) / 3]);
            req = req & ~gnt;
        end

        // Two requesters held continuously must alternate.
        set_ops(0, 3, 3);
        set_ops(2, -2, 9);
        req = 4'b0101;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (gnt != '0) order.push_back(oh_idx(gnt));
        end
        req = '0;
        chk("fair_count", order.size(), 4);
        for (int k = 0; k < 4 && k < order.size(); k++)
            chk("fair_order", order[k], (k % 2 == 0) ? 0 : 2);

        for (int i = 0; i <= 20; i++) begin
            sa = byte'(7 * i);
            sx = byte'(11 * i);
            do_op(i % NREQ, int'(sa), int'(sx), int'(sa) * int'(sx));
        end

        // Reset asserted while the granted operation is in MUL.
        set_ops(0, 5, 5);
        req = 4'b0001;
        tick();
        chk("abort_gnt", int'(gnt), 1);
        rst_n = 1'b0;
        req = '0;
        #1;
        chk("abort_gnt0", int'(gnt), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", sres(), 0);
        chk("abort_rsp", int'(rsp_valid), 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("abort_no_rsp", int'(rsp_valid), 0);
        end
        set_ops(1, 6, -7);
        set_ops(3, -9, 13);
        req = 4'b1010;
        tick();
        chk("post_rst_gnt1", int'(gnt), 2);
        req[1] = 1'b0;
        tick();
        chk("post_rst_rsp1", int'(rsp_valid), 2);
        chk("post_rst_res1", sres(), -42);
        tick();
        tick();
        chk("post_rst_gnt3", int'(gnt), 8);
        req[3] = 1'b0;
        tick();
        chk("post_rst_rsp3", int'(rsp_valid), 8);
        chk("post_rst_res3", sres(), -117);
        tick();
        chk("post_rst_idle", int'(busy), 0);

        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_busy", int'(busy), 0);
            chk("idle_gnt", int'(gnt), 0);
            chk("idle_rsp", int'(rsp_valid), 0);
            chk("idle_result", sres(), -117);
        end

        // Random requesters against a transaction-level model: a request set seen while
        // the arbiter is free goes to the first requester after the last one served.
        do_reset();
        last = NREQ - 1;
        phase = 0;
        cur = 0;
        eres = 0;
        for (int c = 0; c < 400; c++) begin
            r = req;
            eg = '0;
            er = '0;
            if (phase == 0 && r != '0) begin
                w = rr_pick(r, last);
                eg = NREQ'(1 << w);
                last = w;
                cur = ma[w] * mx[w];
                phase = 2;
            end else if (phase > 0) begin
                if (phase == 2) begin
                    er = NREQ'(1 << last);
                    eres = cur;
                end
                phase--;
            end
            tick();
            chk("rnd_gnt", int'(gnt), int'(eg));
            chk("rnd_rsp", int'(rsp_valid), int'(er));
            chk("rnd_busy", int'(busy), int'(phase != 0));
            chk("rnd_result", sres(), eres);
            for (int j = 0; j < NREQ; j++) begin
                if (gnt[j]) req[j] = 1'b0;
                else if (!req[j] && $urandom_range(0, 2) == 0) begin
                    ma[j] = int'($urandom_range(0, 255)) - 128;
                    mx[j] = int'($urandom_range(0, 255)) - 128;
                    set_ops(j, ma[j], mx[j]);
                    req[j] = 1'b1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and sequencer that shares one signed WIDTH×WIDTH multiplier between NREQ requesters. Each requester presents operands with a request. The block grants one requester at a time, latches its operands, and computes the full-precision signed product. It returns the product with a one-hot response strobe. It sits between the client datapaths and the single structural signed multiplier instance, so only one multiplier is built.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width; operands and product are two's complement
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request; must be held with stable operands until its gnt bit is seen
- a_in  in  NREQ*WIDTH  operand A of requester i at bits [i*WIDTH +: WIDTH], signed
- x_in  in  NREQ*WIDTH  operand X of requester i, same packing, signed
- gnt  out  NREQ  registered one-hot grant, high for exactly one cycle
- rsp_valid  out  NREQ  registered one-hot response strobe, high for exactly one cycle
- result  out  2*WIDTH  signed product of the last completed operation; held until the next one completes
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - If any req bit is high, select the winner by round-robin search starting at ptr, ascending, wrapping NREQ-1 → 0.
  - Latch the winner's a_in/x_in into op_a/op_x and its index into id.
  - Set gnt[id] for the next cycle and go to MUL.
  - If no request is present, stay in IDLE.
- MUL:
  - result_nxt = signed(op_a) * signed(op_x), full 2*WIDTH precision with no truncation or saturation.
  - Register result_nxt into result and go to RESP.
  - req is ignored in this state.
- RESP:
  - rsp_valid[id] = 1.
  - ptr ← (id+1) mod NREQ.
  - Go to IDLE. req is ignored in this state.
- Round-robin pointer:
  - ptr resets to 0.
  - The most recently served requester has the lowest priority in the next arbitration.
  - A requester still holding req cannot be starved: it wins within NREQ operations.
- Requester rule:
  - Deassert req in the cycle after gnt is seen.
  - A req still high when the block returns to IDLE is treated as a new request.
- Product range for WIDTH=8: −16256..16384. −128 × −128 = 16384 fits in 16 bits signed.
- Reset (asynchronous, any state, including mid-MUL or mid-RESP):
  - state=IDLE, ptr=0, op_a/op_x/id=0.
  - gnt=0, rsp_valid=0, result=0, busy=0.
  - An aborted operation never produces rsp_valid. After rst_n rises, the requester must re-request.

## Timing
- Cycle 0: state IDLE, req[i]=1 sampled at the rising edge ending cycle 0.
- Cycle 1: gnt[i]=1, state MUL, busy=1.
- Cycle 2: state RESP. rsp_valid[i]=1 and result is valid, busy=1.
- Cycle 3: state IDLE, busy=0. Earliest next arbitration is at the edge ending cycle 3.
- Request-to-response latency is 2 cycles. Sustained throughput is one product per 3 cycles.
- gnt and rsp_valid are never high at the same time. At most one bit of each is set.
- result changes only on the edge entering RESP, and is stable from RESP until the next RESP.

## Test plan
- Single request:
  - req0 with A=7, X=11 → gnt=0001 in cycle 1.
  - rsp_valid=0001 with result=77 in cycle 2.
  - busy low in cycle 3.
- Simultaneous requests:
  - All four requesters from reset with (A,X) = (1,2), (−3,4), (5,−6), (−7,−8).
  - Requesters drop req after their grant.
  - Grants in order 0,1,2,3, 3 cycles apart; results 2, −12, −30, 56.
- Fairness:
  - req0 and req2 held continuously.
  - Grants alternate 0,2,0,2. req0 never wins twice in a row.
- Extremes:
  - −128 × −128 → 16384.
  - −128 × 127 → −16256.
  - 0 × −1 → 0.
  - Sweep i=0..20 with A=7i, X=11i, where 7i and 11i wrap as 8-bit two's complement. Each result equals the signed product of the wrapped 8-bit values.
- Reset during MUL:
  - Drop rst_n in the MUL cycle → all outputs 0 immediately and no rsp_valid afterward.
  - After reset, with req1 and req3 both pending, req1 wins because ptr=0.
- Idle hold:
  - No req for 10 cycles after a response → busy=0, gnt=0, rsp_valid=0, and result keeps its last value.
